// File: rtl/approx_mul_rr_sched_pkg.sv
// Shared constants and the round-robin pick function for the approximate
// multiplier scheduler.
package approx_mul_pkg;

    localparam int OPW      = 8;
    localparam int PRODW    = 16;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [MAX_REQ-1:0]  onehot;
        logic [MAX_ID_W-1:0] idx;
        logic                any;
    } rr_pick_t;

    // Search last+1 .. last+n (mod n) and return the first active request.
    function automatic rr_pick_t rr_grant(input logic [MAX_REQ-1:0]  req,
                                          input logic [MAX_ID_W-1:0] last,
                                          input int                  n);
        rr_pick_t p;
        int       j;
        p = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                j = int'(last) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!p.any && req[j]) begin
                    p.any       = 1'b1;
                    p.idx       = j[MAX_ID_W-1:0];
                    p.onehot[j] = 1'b1;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/approx_mul_rr_sched_if.sv
// Request, shared-core and response signals of the multiplier scheduler.
interface approx_mul_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_x;
    logic [8*NUM_REQ-1:0] req_y;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           mul_x;
    logic [7:0]           mul_y;
    logic [15:0]          mul_z;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [15:0]          rsp_z;
    logic [ID_W-1:0]      rsp_id;
    logic [CNT_W-1:0]     op_count;

    // Requesters, external core and response consumer.
    modport master (
        output req_valid, req_x, req_y, mul_z, rsp_ready,
        input  req_ready, mul_x, mul_y, rsp_valid, rsp_z, rsp_id, op_count
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_x, req_y, mul_z, rsp_ready,
        output req_ready, mul_x, mul_y, rsp_valid, rsp_z, rsp_id, op_count
    );
endinterface

// File: rtl/approx_mul_rr_sched_rr_arbiter.sv
// Combinational round-robin picker; the pointer lives in the parent.
module rr_arbiter
    import approx_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);
    rr_pick_t w_pick;

    assign w_pick = rr_grant(MAX_REQ'(i_req), MAX_ID_W'(i_last), NUM_REQ);

    // Expose the pick only while the operand stage can take a new operation.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        if (i_en) begin
            o_grant = w_pick.onehot[NUM_REQ-1:0];
            o_idx   = w_pick.idx[ID_W-1:0];
            o_any   = w_pick.any;
        end else begin
            o_grant = '0;
            o_idx   = '0;
            o_any   = 1'b0;
        end
    end
endmodule

// File: rtl/approx_mul_rr_sched.sv
// Round-robin scheduler sharing one external 8x8 approximate multiplier
// among NUM_REQ requesters: operand stage S0, result stage S1.
module approx_mul_rr_sched
    import approx_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    approx_mul_rr_sched_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic                 r_s0_valid;
    logic [OPW-1:0]       r_s0_x;
    logic [OPW-1:0]       r_s0_y;
    logic [ID_W-1:0]      r_s0_id;
    logic                 r_s1_valid;
    logic [PRODW-1:0]     r_s1_z;
    logic [ID_W-1:0]      r_s1_id;
    logic [ID_W-1:0]      r_last_grant;
    logic [CNT_W-1:0]     r_op_count;

    logic                 w_s1_free;
    logic                 w_s0_adv;
    logic                 w_s0_free;
    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_idx;
    logic                 w_hs;

    assign w_s1_free = !r_s1_valid || bus.rsp_ready;
    assign w_s0_adv  = r_s0_valid && w_s1_free;
    assign w_s0_free = !r_s0_valid || w_s0_adv;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_last  (r_last_grant),
        .i_en    (w_s0_free),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_hs)
    );

    // Grant depends on req_valid within the cycle; the arbiter only fires on a valid request.
    assign bus.req_ready = w_grant;
    // S0 operands are cleared when S0 empties, so the idle core sees zeros.
    assign bus.mul_x     = r_s0_x;
    assign bus.mul_y     = r_s0_y;
    assign bus.rsp_valid = r_s1_valid;
    assign bus.rsp_z     = r_s1_z;
    assign bus.rsp_id    = r_s1_id;
    assign bus.op_count  = r_op_count;

    // Operand stage: load on handshake, empty (and zero operands) on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_x     <= '0;
            r_s0_y     <= '0;
            r_s0_id    <= '0;
        end else if (w_hs) begin
            r_s0_valid <= 1'b1;
            r_s0_x     <= bus.req_x[int'(w_idx)*OPW +: OPW];
            r_s0_y     <= bus.req_y[int'(w_idx)*OPW +: OPW];
            r_s0_id    <= w_idx;
        end else if (w_s0_adv) begin
            r_s0_valid <= 1'b0;
            r_s0_x     <= '0;
            r_s0_y     <= '0;
        end
    end

    // Result stage: capture the core product, drain when the consumer accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_z     <= '0;
            r_s1_id    <= '0;
        end else if (w_s0_adv) begin
            r_s1_valid <= 1'b1;
            r_s1_z     <= bus.mul_z;
            r_s1_id    <= r_s0_id;
        end else if (w_s1_free) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Round-robin pointer and accepted-operation counter advance per handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_op_count   <= '0;
        end else if (w_hs) begin
            r_last_grant <= w_idx;
            r_op_count   <= r_op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// Self-checking bench: vector table, directed corner sequences and a
// response scoreboard fed from observed request handshakes.
module tb_approx_mul_rr_sched;
    logic clk;
    logic rst;

    approx_mul_rr_sched_if #(.NUM_REQ(4), .CNT_W(16)) bus ();

    approx_mul_rr_sched #(.NUM_REQ(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Exact reference multiplier standing in for the approximate core.
    assign bus.mul_z = 16'(bus.mul_x) * 16'(bus.mul_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] z;
    } exp_t;

    typedef struct {
        logic [1:0]  id;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
    } vec_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_ops    = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] x, input logic [7:0] y);
        bus.req_x[8*i +: 8] = x;
        bus.req_y[8*i +: 8] = y;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            step();
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Scoreboard: compare responses taken this cycle, record handshakes.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id=%0d z=%0d expected none at %0t",
                             bus.rsp_id, bus.rsp_z, $time);
                end else begin
                    e = sb.pop_front();
                    check("sb_id", bus.rsp_id, e.id);
                    check("sb_z", bus.rsp_z, e.z);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    e.id = 2'(i);
                    e.z  = 16'(bus.req_x[8*i +: 8]) * 16'(bus.req_y[8*i +: 8]);
                    sb.push_back(e);
                    m_ops = m_ops + 16'd1;
                end
            end
        end
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{id: 2'd2, x: 8'd13,  y: 8'd11,  z: 16'd143};
        vecs[1] = '{id: 2'd0, x: 8'd255, y: 8'd255, z: 16'd65025};
        vecs[2] = '{id: 2'd1, x: 8'd0,   y: 8'd200, z: 16'd0};
        vecs[3] = '{id: 2'd2, x: 8'd128, y: 8'd2,   z: 16'd256};
        vecs[4] = '{id: 2'd0, x: 8'd100, y: 8'd100, z: 16'd10000};
        vecs[5] = '{id: 2'd3, x: 8'd7,   y: 8'd9,   z: 16'd63};

        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_x     = 32'd0;
        bus.req_y     = 32'd0;
        bus.rsp_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_z", bus.rsp_z, 0);
        check("rst_op_count", bus.op_count, 0);
        check("rst_mul_x", bus.mul_x, 0);
        check("rst_mul_y", bus.mul_y, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("idle_mul_x", bus.mul_x, 0);
            check("idle_mul_y", bus.mul_y, 0);
            check("idle_ready", bus.req_ready, 0);
        end

        // Table-driven single requests with latency check.
        for (int v = 0; v < 6; v++) begin
            set_lane(vecs[v].id, vecs[v].x, vecs[v].y);
            bus.req_valid = 4'b0001 << vecs[v].id;
            #1;
            check("vec_ready", bus.req_ready, 4'b0001 << vecs[v].id);
            step();
            bus.req_valid = 4'b0000;
            check("vec_rsp_early", bus.rsp_valid, 0);
            step();
            check("vec_rsp_valid", bus.rsp_valid, 1);
            check("vec_rsp_z", bus.rsp_z, vecs[v].z);
            check("vec_rsp_id", bus.rsp_id, vecs[v].id);
            check("vec_op_count", bus.op_count, v + 1);
            step();
        end
        drain();
        check("vec_idle_mul_x", bus.mul_x, 0);

        // Fairness: all requesters valid, one grant per cycle in rotation.
        for (int i = 0; i < 4; i++) set_lane(i, 8'(i + 1), 8'(10 + i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fair_grant", bus.req_ready, 4'b0001 << (k % 4));
            step();
        end
        bus.req_valid = 4'b0000;
        drain();
        check("fair_op_count", bus.op_count, 14);

        // Backpressure: three ops from requester 1, stall on first response.
        set_lane(1, 8'd2, 8'd5);
        bus.req_valid = 4'b0010;
        #1;
        check("bp_ready0", bus.req_ready, 4'b0010);
        step();
        set_lane(1, 8'd3, 8'd5);
        #1;
        check("bp_ready1", bus.req_ready, 4'b0010);
        step();
        set_lane(1, 8'd4, 8'd5);
        bus.rsp_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_z", bus.rsp_z, 10);
            check("bp_hold_id", bus.rsp_id, 1);
            check("bp_full_ready", bus.req_ready, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = 4'b0000;
        drain();
        check("bp_op_count", bus.op_count, 17);

        // Reset with two operations in flight.
        bus.rsp_ready = 1'b0;
        set_lane(1, 8'd9, 8'd9);
        bus.req_valid = 4'b0010;
        step();
        set_lane(2, 8'd5, 8'd6);
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b0000;
        #2;
        rst = 1'b1;
        sb.delete();
        m_ops = 16'd0;
        #1;
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_rsp_z", bus.rsp_z, 0);
        check("arst_rsp_id", bus.rsp_id, 0);
        check("arst_op_count", bus.op_count, 0);
        check("arst_mul_x", bus.mul_x, 0);
        check("arst_mul_y", bus.mul_y, 0);
        step();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("arst_no_rsp", bus.rsp_valid, 0);
            step();
        end
        set_lane(0, 8'd3, 8'd4);
        set_lane(3, 8'd6, 8'd7);
        bus.req_valid = 4'b1001;
        #1;
        check("arst_first_grant", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = 4'b0000;
        drain();
        check("arst_op_count1", bus.op_count, 1);

        // Counter wrap: 65535 more accepts bring the count back to 0.
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 65535; k++) begin
            bus.req_x = $urandom();
            bus.req_y = $urandom();
            step();
        end
        bus.req_valid = 4'b0000;
        drain();
        check("wrap_op_count", bus.op_count, 0);
        check("wrap_model_count", bus.op_count, m_ops);

        check("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/approx_mul_rr_sched.md
Name: approx_mul_rr_sched

Overview:
- Shares one combinational 8x8 unsigned approximate multiplier core among NUM_REQ requesters, e.g. LeNet conv/FC lanes.
- Arbitrates round-robin and drives the shared core's operands from a registered stage.
- Captures the 16-bit product in a result register and returns it with the requester ID over a valid/ready response channel with full backpressure.
- The core sits outside this block and is connected via the mul_x, mul_y and mul_z ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID (derived; do not override).
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_x  in  8*NUM_REQ  packed multiplicand; requester i uses bits [8i+7:8i].
- req_y  in  8*NUM_REQ  packed multiplier, same packing as req_x.
- req_ready  out  NUM_REQ  one-hot grant; handshake on req_valid[i] & req_ready[i].
- mul_x  out  8  operand A to the shared multiplier core.
- mul_y  out  8  operand B to the shared multiplier core.
- mul_z  in  16  combinational product returned by the core.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts the result.
- rsp_z  out  16  product.
- rsp_id  out  ID_W  index of the requester that issued the operation.
- op_count  out  CNT_W  number of accepted requests, wrapping.

Behaviour:
- Reset (asynchronous, takes effect immediately, any state):
  - s0_valid = 0, s1_valid = 0.
  - rsp_z, rsp_id, op_count = 0; mul_x, mul_y = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - In-flight operations are discarded and never produce a response.
- Pipeline:
  - S0 is the operand register: x, y, id.
  - S1 is the result register: z, id. rsp_valid = s1_valid, rsp_z = s1_z, rsp_id = s1_id.
  - s1_free = !s1_valid | rsp_ready.
  - s0_adv = s0_valid & s1_free; on s0_adv, S1 loads {mul_z, s0_id}.
  - If s1_free and !s0_valid, S1 clears s1_valid.
  - s0_free = !s0_valid | s0_adv.
- Operand drive: mul_x = s0_x and mul_y = s0_y when s0_valid, else 0. Zero operands keep the core from toggling when idle.
- Latency: accepting handshake in cycle N -> rsp_valid in cycle N+2, provided rsp_ready was high.
- Throughput: one operation per cycle while rsp_ready = 1.
- Arbitration:
  - When s0_free, grant the first i with req_valid[i], searching last_grant+1 ... last_grant+NUM_REQ modulo NUM_REQ.
  - req_ready = one-hot grant; all zero when !s0_free or no request is pending.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- On handshake:
  - S0 loads the granted x, y and id; s0_valid = 1.
  - last_grant = granted index; op_count += 1, wrapping at 2^CNT_W.
- No handshake: last_grant and op_count hold.
- Backpressure:
  - While rsp_valid & !rsp_ready, rsp_z and rsp_id hold stable and S1 does not change.
  - S0 holds if occupied; at most 2 operations are in flight.
  - No loss and no duplication.
- Simultaneous events:
  - Response drain, S0->S1 advance and a new grant may all occur in the same cycle.
  - A requester that stays valid after its handshake re-competes with the pointer already past it.
- req_x/req_y of non-granted requesters are ignored.

Decomposition:
- Shared package approx_mul_pkg holds:
  - OPW = 8, PRODW = 16.
  - The rr_grant function (request vector, last index -> one-hot, index, any).
- Single sub-module: rr_arbiter, a parameterised combinational round-robin picker with the pointer held in the parent.
- The multiplier core stays external, so different approximate variants can be swapped in without touching this block.

Test Plan:
- Bench model for every scenario: mul_z = mul_x*mul_y (exact), computed combinationally.
- Reset: assert rst asynchronously (mid-cycle) -> rsp_valid, rsp_z, op_count, mul_x and mul_y read 0 immediately; after release, an idle bench with req_valid = 0 keeps mul_x = mul_y = 0.
- Single request: req 2 with x=13, y=11, rsp_ready=1 -> req_ready=4'b0100 in the same cycle; two cycles later rsp_valid=1, rsp_z=143, rsp_id=2; op_count=1.
- Fairness: all 4 requesters held valid, rsp_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one per cycle, and rsp_id shows the same sequence 2 cycles later; op_count=8.
- Backpressure: 3 back-to-back requests from req 1 (x=2,3,4; y=5), rsp_ready low for 5 cycles starting when the first response appears -> rsp_z holds 10 and rsp_id holds 1; req_ready=0 once S0 and S1 are full; after release, responses are 10, 15, 20 in order with none lost.
- Boundaries:
  - x=255, y=255 -> rsp_z=65025.
  - x=0, y=200 -> rsp_z=0.
  - 65536 accepts -> op_count wraps to 0.
- Reset mid-flight: two operations in flight, then rst pulse -> no response appears for either; the next grant goes to requester 0 even when requester 3 is also valid.
